// File: rtl/alu_result_writer_if.sv
`default_nettype none
// =============================================================================
// Interface : alu_result_writer_if
// ALU result strobe, result-RAM port and host readback port of the writer.
// Revision  : 1.0
// =============================================================================
interface alu_result_writer_if #(
    parameter int MU_W   = 18,
    parameter int ADDR_W = 4
);
    // ALU result side
    logic              web;
    logic [MU_W-1:0]   MU1;
    logic [MU_W-1:0]   MU2;
    logic [MU_W-1:0]   MU3;
    logic [MU_W-1:0]   MU4;
    logic              ALU_done;

    // Single-port result RAM
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [MU_W-1:0]   ram_wdata;
    logic [MU_W-1:0]   ram_rdata;

    // Host readback
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [MU_W-1:0]   rd_data;

    // Status
    logic              busy;
    logic              res_done;
    logic              overflow;

    modport master (
        output web, MU1, MU2, MU3, MU4, ALU_done,
        output ram_rdata, rd_en, rd_addr,
        input  ram_cs, ram_we, ram_addr, ram_wdata,
        input  rd_valid, rd_data, busy, res_done, overflow
    );

    modport slave (
        input  web, MU1, MU2, MU3, MU4, ALU_done,
        input  ram_rdata, rd_en, rd_addr,
        output ram_cs, ram_we, ram_addr, ram_wdata,
        output rd_valid, rd_data, busy, res_done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_writer.sv
`default_nettype none
// =============================================================================
// Module   : alu_result_writer
// Captures ALU row sums into a two-slot buffer, serialises them into a
// single-port result RAM and lends idle RAM cycles to host readback.
// Revision : 1.0
// =============================================================================
module alu_result_writer #(
    parameter int MU_W         = 18,
    parameter int ADDR_W       = 4,
    parameter int ROWS_PER_RUN = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_result_writer_if.slave bus
);
    localparam int c_ROW_WORDS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef logic [c_ROW_WORDS-1:0][MU_W-1:0] row_t;

    if (c_ROW_WORDS * ROWS_PER_RUN > (1 << ADDR_W)) begin : g_run_fit_check
        $error("a run of ROWS_PER_RUN rows does not fit in the result RAM");
    end

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_sub;
    logic [ADDR_W-1:0] r_wr_ptr;

    row_t              w_in_row;
    row_t              r_act_row;
    row_t              r_pend_row;
    row_t              w_act_row_nx;
    row_t              w_pend_row_nx;
    logic              r_act_full;
    logic              r_pend_full;
    logic              w_act_full_nx;
    logic              w_pend_full_nx;
    logic              w_drop;

    logic              r_done_pend;
    logic              w_done_pend_any;
    logic              r_overflow;
    logic              w_row_end;

    logic              w_rd_accept;
    logic              r_rd_valid;
    logic [MU_W-1:0]   r_rd_hold;

    logic              w_ram_cs;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [MU_W-1:0]   w_ram_wdata;
    logic              w_res_done;

    assign w_in_row        = {bus.MU4, bus.MU3, bus.MU2, bus.MU1};
    assign w_row_end       = (r_state == S_WRITE) && (r_sub == 2'(c_ROW_WORDS - 1));
    assign w_done_pend_any = r_done_pend | bus.ALU_done;

    // Slot bookkeeping: the row finishing this cycle frees the active slot
    // before the incoming web picks its slot, so a web on the last word
    // of a row is never counted as an overflow.
    always_comb begin
        w_act_full_nx  = r_act_full;
        w_pend_full_nx = r_pend_full;
        w_act_row_nx   = r_act_row;
        w_pend_row_nx  = r_pend_row;
        w_drop         = 1'b0;
        if (w_row_end) begin
            w_act_full_nx  = r_pend_full;
            w_act_row_nx   = r_pend_row;
            w_pend_full_nx = 1'b0;
        end
        if (bus.web) begin
            if (!w_act_full_nx) begin
                w_act_full_nx = 1'b1;
                w_act_row_nx  = w_in_row;
            end else if (!w_pend_full_nx) begin
                w_pend_full_nx = 1'b1;
                w_pend_row_nx  = w_in_row;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Leaving IDLE on the web itself (not on the registered slot flag)
    // is what puts the first word on the RAM one cycle after the strobe.
    always_comb begin
        w_state_nx  = r_state;
        w_ram_cs    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_wr_ptr;
        w_ram_wdata = r_act_row[r_sub];
        w_rd_accept = 1'b0;
        w_res_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rd_en && !r_act_full && !r_pend_full && !bus.web) begin
                    w_rd_accept = 1'b1;
                    w_ram_cs    = 1'b1;
                    w_ram_addr  = bus.rd_addr;
                end
                if (w_act_full_nx) begin
                    w_state_nx = S_WRITE;
                end else if (w_done_pend_any) begin
                    w_state_nx = S_DONE;
                end
            end
            S_WRITE: begin
                w_ram_cs = 1'b1;
                w_ram_we = 1'b1;
                if (w_row_end) begin
                    if (w_act_full_nx) begin
                        w_state_nx = S_WRITE;
                    end else if (w_done_pend_any) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_res_done = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sub       <= '0;
            r_wr_ptr    <= '0;
            r_act_row   <= '0;
            r_pend_row  <= '0;
            r_act_full  <= 1'b0;
            r_pend_full <= 1'b0;
            r_done_pend <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_hold   <= '0;
        end else begin
            r_act_row   <= w_act_row_nx;
            r_pend_row  <= w_pend_row_nx;
            r_act_full  <= w_act_full_nx;
            r_pend_full <= w_pend_full_nx;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // A run-end strobe landing on the DONE cycle opens the next run.
            r_done_pend <= bus.ALU_done | (r_done_pend & (r_state != S_DONE));
            if (r_state == S_WRITE) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_sub    <= r_sub + 1'b1;
            end else begin
                r_sub <= '0;
                if (r_state == S_DONE) begin
                    r_wr_ptr <= '0;
                end
            end
            r_rd_valid <= w_rd_accept;
            if (r_rd_valid) begin
                r_rd_hold <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_cs    = w_ram_cs;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_valid ? bus.ram_rdata : r_rd_hold;
    assign bus.busy      = (r_state != S_IDLE) | r_act_full | r_pend_full;
    assign bus.res_done  = w_res_done;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_writer.sv
`default_nettype none
// Bench for alu_result_writer: RAM model, write scoreboard, table-driven run
// and hand sequences for back-to-back capture, readback and mid-row reset.
`timescale 1ns/1ps
module tb_alu_result_writer;
    localparam int MU_W   = 18;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_result_writer_if #(.MU_W(MU_W), .ADDR_W(ADDR_W)) bus();

    alu_result_writer #(.MU_W(MU_W), .ADDR_W(ADDR_W), .ROWS_PER_RUN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MU_W-1:0]   data;
    } wr_t;

    typedef struct {
        logic [MU_W-1:0] mu [4];
        logic            done;
        int              gap;
    } vec_t;

    logic [MU_W-1:0] ram     [DEPTH];
    logic [MU_W-1:0] exp_mem [DEPTH];
    wr_t             exp_q   [$];
    vec_t            tbl     [4];
    int              total   = 0;
    int              bad     = 0;
    int              exp_ptr = 0;

    // Result RAM: 1-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        else if (bus.ram_cs)          bus.ram_rdata     <= ram[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.ram_cs === 1'b1 && bus.ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.ram_wdata), 32'(e.data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [MU_W-1:0] m [4], input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = 4'(exp_ptr);
            w.data = m[i];
            exp_q.push_back(w);
            exp_mem[exp_ptr] = m[i];
            exp_ptr = (exp_ptr + 1) % DEPTH;
        end
    endtask

    task automatic drive_web(input logic [MU_W-1:0] m [4], input logic done);
        bus.web      = 1'b1;
        bus.MU1      = m[0];
        bus.MU2      = m[1];
        bus.MU3      = m[2];
        bus.MU4      = m[3];
        bus.ALU_done = done;
    endtask

    task automatic idle_inputs();
        bus.web      = 1'b0;
        bus.ALU_done = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cs"},       32'(bus.ram_cs),   0);
        chk({tag, "_we"},       32'(bus.ram_we),   0);
        chk({tag, "_busy"},     32'(bus.busy),     0);
        chk({tag, "_res_done"}, 32'(bus.res_done), 0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        chk({tag, "_rd_data"},  32'(bus.rd_data),  0);
    endtask

    // Called just after a posedge with the write path idle
    task automatic do_read(input int a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'(a);
        @(negedge clk);
        chk("rd_cs",   32'(bus.ram_cs),   1);
        chk("rd_we",   32'(bus.ram_we),   0);
        chk("rd_addr", 32'(bus.ram_addr), 32'(a));
        cyc();
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("rd_valid", 32'(bus.rd_valid), 1);
        chk("rd_data",  32'(bus.rd_data),  32'(exp_mem[a]));
        cyc();
        @(negedge clk);
        chk("rd_valid_drop", 32'(bus.rd_valid), 0);
        chk("rd_data_hold",  32'(bus.rd_data),  32'(exp_mem[a]));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [MU_W-1:0] m [4];

        tbl[0].mu = '{18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555}; tbl[0].done = 1'b0; tbl[0].gap = 8;
        tbl[1].mu = '{18'h12345, 18'h0ABCD, 18'h3F00F, 18'h00F0F}; tbl[1].done = 1'b0; tbl[1].gap = 8;
        tbl[2].mu = '{18'h00001, 18'h00002, 18'h20000, 18'h1FFFF}; tbl[2].done = 1'b0; tbl[2].gap = 8;
        tbl[3].mu = '{18'h3C3C3, 18'h03C3C, 18'h11111, 18'h2EEEE}; tbl[3].done = 1'b1; tbl[3].gap = 8;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            exp_mem[i] = '0;
        end
        bus.web = 1'b0; bus.ALU_done = 1'b0;
        bus.MU1 = '0; bus.MU2 = '0; bus.MU3 = '0; bus.MU4 = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        cyc();
        rst = 1'b1;

        // Single row: writes land at T+1..T+4
        cyc();
        m = '{18'd1, 18'd2, 18'd3, 18'd4};
        drive_web(m, 1'b0);
        push_words(m, 4);
        cyc();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("row1_cs",    32'(bus.ram_cs),    1);
            chk("row1_addr",  32'(bus.ram_addr),  32'(i));
            chk("row1_wdata", 32'(bus.ram_wdata), 32'(i + 1));
            chk("row1_busy",  32'(bus.busy),      1);
            cyc();
        end
        @(negedge clk);
        chk("row1_after_cs",   32'(bus.ram_cs), 0);
        chk("row1_after_busy", 32'(bus.busy),   0);

        // Clear wr_ptr before the full run
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_ptr = 0;

        // Full run from the vector table; res_done exactly at T4+5
        for (int r = 0; r < 4; r++) begin
            m = tbl[r].mu;
            drive_web(m, tbl[r].done);
            push_words(m, 4);
            cyc();
            idle_inputs();
            for (int k = 1; k < tbl[r].gap; k++) begin
                @(negedge clk);
                chk($sformatf("run_res_done_r%0d_k%0d", r, k),
                    32'(bus.res_done), 32'(tbl[r].done && k == 5));
                cyc();
            end
        end
        chk("run_queue_empty", 32'(exp_q.size()), 0);

        // Host readback in IDLE
        do_read(5);
        do_read(0);
        do_read(15);
        do_read(10);

        // Back-to-back webs, third overflows; rd_en during WRITE is ignored
        m = '{18'h0AAA1, 18'h0AAA2, 18'h0AAA3, 18'h0AAA4};
        drive_web(m, 1'b0);
        push_words(m, 4);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 1) begin
                m = '{18'h0BBB1, 18'h0BBB2, 18'h0BBB3, 18'h0BBB4};
                drive_web(m, 1'b0);
                push_words(m, 4);
            end else if (k == 2) begin
                m = '{18'h0CCC1, 18'h0CCC2, 18'h0CCC3, 18'h0CCC4};
                drive_web(m, 1'b0);
            end else if (k == 3) begin
                idle_inputs();
                bus.rd_en   = 1'b1;
                bus.rd_addr = 4'd3;
            end else if (k == 7) begin
                bus.rd_en = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b2b_cs_k%0d", k),       32'(bus.ram_cs),   1);
            chk($sformatf("b2b_we_k%0d", k),       32'(bus.ram_we),   1);
            chk($sformatf("b2b_rd_valid_k%0d", k), 32'(bus.rd_valid), 0);
        end
        cyc();
        @(negedge clk);
        chk("b2b_end_cs",    32'(bus.ram_cs),   0);
        chk("b2b_overflow",  32'(bus.overflow), 1);
        chk("b2b_end_busy",  32'(bus.busy),     0);
        cyc();
        do_read(1);
        do_read(8);

        // Reset while sub==2 of a row
        m = '{18'h0DDD1, 18'h0DDD2, 18'h0DDD3, 18'h0DDD4};
        drive_web(m, 1'b0);
        push_words(m, 3);
        cyc();
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_addr", 32'(bus.ram_addr), 10);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rst_mid");
        exp_ptr = 0;
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("rst_mid_no_write", 32'(bus.ram_cs), 0);
        end
        cyc();
        m = '{18'h0EEE1, 18'h0EEE2, 18'h0EEE3, 18'h0EEE4};
        drive_web(m, 1'b0);
        push_words(m, 4);
        cyc();
        idle_inputs();
        repeat (6) cyc();
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        do_read(2);
        do_read(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
